// File: rtl/gray_count_pkg.sv
// Shared helpers for the gray-coded event counter crossing.
package gray_count_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  // Works for any width up to 32 when the value is zero-extended.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

  // Binary to gray, used on the source side of the crossing.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_count_rx_sync.sv
// Plain flop chain for a gray-coded bus; only one bit moves per source step,
// so per-bit synchronization is safe.
module sync_ff_bus #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // Shift the bus through the synchronizer stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/gray_count_rx.sv
// Destination side of the gray counter crossing: synchronize, decode, and
// turn per-sample count deltas into a poppable pool of pending events.
module gray_count_rx
  import gray_count_pkg::*;
#(
  parameter int WIDTH_P       = 4,
  parameter int SYNC_STAGES_P = DEFAULT_SYNC_STAGES,
  parameter int PEND_W_P      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH_P-1:0]  gray_in,
  input  logic                clr,
  input  logic                pop_ready,
  output logic                pop_valid,
  output logic [PEND_W_P-1:0] pending,
  output logic [WIDTH_P-1:0]  val,
  output logic                non_zero,
  output logic                ovf
);

  localparam int SUM_W = PEND_W_P + 1;

  logic [WIDTH_P-1:0]  w_gray_q;
  logic [31:0]         w_bin_full;
  logic                w_unused_bin_hi;
  logic [WIDTH_P-1:0]  w_delta;
  logic                w_pop;
  logic [SUM_W-1:0]    w_sum;

  logic [WIDTH_P-1:0]  r_cur_bin;
  logic [WIDTH_P-1:0]  r_last_bin;
  logic [PEND_W_P-1:0] r_pending;
  logic                r_ovf;

  sync_ff_bus #(
    .WIDTH  (WIDTH_P),
    .STAGES (SYNC_STAGES_P)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (gray_in),
    .o_q   (w_gray_q)
  );

  assign w_bin_full      = gray2bin(32'(w_gray_q));
  assign w_unused_bin_hi = ^w_bin_full[31:WIDTH_P];

  // Modular subtraction makes the 2^WIDTH_P-1 -> 0 wrap count as a single step.
  assign w_delta = r_cur_bin - r_last_bin;
  assign w_pop   = pop_valid && pop_ready;
  // One extra bit catches saturation; pops only occur when pending is nonzero,
  // so the subtraction never underflows.
  assign w_sum   = {1'b0, r_pending} + SUM_W'(w_delta) - SUM_W'(w_pop);

  // Register the decoded count and remember the previous sample for the delta.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_bin  <= '0;
      r_last_bin <= '0;
    end else begin
      r_cur_bin  <= w_bin_full[WIDTH_P-1:0];
      r_last_bin <= r_cur_bin;
    end
  end

  // Pending-event pool with saturation and sticky overflow; clr drops this cycle's delta and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_ovf     <= 1'b0;
    end else if (clr) begin
      r_pending <= '0;
      r_ovf     <= 1'b0;
    end else if (w_sum[PEND_W_P]) begin
      r_pending <= '1;
      r_ovf     <= 1'b1;
    end else begin
      r_pending <= w_sum[PEND_W_P-1:0];
    end
  end

  assign pending   = r_pending;
  assign pop_valid = |r_pending;
  assign val       = r_cur_bin;
  assign non_zero  = |r_cur_bin;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_gray_count_rx.sv
// Self-checking bench for gray_count_rx: directed scenarios plus a randomized
// run against an event-count model of the source counter.
module tb_gray_count_rx;
  import gray_count_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] gray_in;
  logic       clr;
  logic       pop_ready;
  logic       pop_valid;
  logic [7:0] pending;
  logic [3:0] val;
  logic       non_zero;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: source count history (h[0] = value seen at the latest edge),
  // event credit pool and overflow flag.
  int m_src = 0;
  int m_pending = 0;
  int m_val = 0;
  bit m_ovf = 1'b0;
  int h[5];

  gray_count_rx #(
    .WIDTH_P       (4),
    .SYNC_STAGES_P (2),
    .PEND_W_P      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .gray_in   (gray_in),
    .clr       (clr),
    .pop_ready (pop_ready),
    .pop_valid (pop_valid),
    .pending   (pending),
    .val       (val),
    .non_zero  (non_zero),
    .ovf       (ovf)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic set_src(input int v);
    m_src   = v % 16;
    gray_in = 4'(bin2gray(32'(m_src)));
  endtask

  // Advance one clock and update the model: a source step becomes visible on val
  // two edges after it is sampled and is credited to the pool one edge later.
  task automatic tick();
    int d;
    int sum;
    bit pop;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 5; i++) h[i] = 0;
      m_pending = 0;
      m_ovf     = 1'b0;
    end else begin
      for (int i = 4; i > 0; i--) h[i] = h[i-1];
      h[0] = m_src;
      d   = ((h[3] - h[4]) % 16 + 16) % 16;
      pop = (m_pending != 0) && pop_ready;
      if (clr) begin
        m_pending = 0;
        m_ovf     = 1'b0;
      end else begin
        sum = m_pending + d - (pop ? 1 : 0);
        if (sum > 255) begin
          m_pending = 255;
          m_ovf     = 1'b1;
        end else begin
          m_pending = sum;
        end
      end
    end
    m_val = h[2];
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clr = 1'b0; pop_ready = 1'b0; set_src(0);
    repeat (3) tick();
    checks += 5;
    if (val !== 4'd0)    begin errors++; $display("FAIL reset_val got %0d expected 0", val); end
    if (non_zero !== 0)  begin errors++; $display("FAIL reset_non_zero got %0b expected 0", non_zero); end
    if (pending !== 8'd0) begin errors++; $display("FAIL reset_pending got %0d expected 0", pending); end
    if (pop_valid !== 0) begin errors++; $display("FAIL reset_pop_valid got %0b expected 0", pop_valid); end
    if (ovf !== 0)       begin errors++; $display("FAIL reset_ovf got %0b expected 0", ovf); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_steps();
    set_src(1);
    repeat (2) tick();
    checks++;
    if (val !== 4'd0) begin errors++; $display("FAIL step1_early_val got %0d expected 0", val); end
    tick();
    checks += 2;
    if (val !== 4'd1)   begin errors++; $display("FAIL step1_val got %0d expected 1", val); end
    if (non_zero !== 1) begin errors++; $display("FAIL step1_non_zero got %0b expected 1", non_zero); end
    tick();
    checks++;
    if (pending !== 8'd1) begin errors++; $display("FAIL step1_pending got %0d expected 1", pending); end
    tick();
    set_src(2);
    repeat (3) tick();
    checks++;
    if (val !== 4'd2) begin errors++; $display("FAIL step2_val got %0d expected 2", val); end
    repeat (2) tick();
    checks += 2;
    if (pending !== 8'd2) begin errors++; $display("FAIL step2_pending got %0d expected 2", pending); end
    if (pop_valid !== 1)  begin errors++; $display("FAIL step2_pop_valid got %0b expected 1", pop_valid); end
    pop_ready = 1'b1;
    tick();
    checks++;
    if (pending !== 8'd1) begin errors++; $display("FAIL pop1_pending got %0d expected 1", pending); end
    tick();
    checks += 2;
    if (pending !== 8'd0) begin errors++; $display("FAIL pop2_pending got %0d expected 0", pending); end
    if (pop_valid !== 0)  begin errors++; $display("FAIL pop2_pop_valid got %0b expected 0", pop_valid); end
    tick();
    checks++;
    if (pending !== 8'd0) begin errors++; $display("FAIL pop3_ignored got %0d expected 0", pending); end
    pop_ready = 1'b0;
  endtask

  task automatic test_wrap();
    set_src(15);
    repeat (6) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    checks += 2;
    if (pending !== 8'd0) begin errors++; $display("FAIL wrap_pre_pending got %0d expected 0", pending); end
    if (val !== 4'd15)    begin errors++; $display("FAIL wrap_pre_val got %0d expected 15", val); end
    set_src(0);
    repeat (3) tick();
    checks += 3;
    if (val !== 4'd0)     begin errors++; $display("FAIL wrap_val got %0d expected 0", val); end
    if (non_zero !== 0)   begin errors++; $display("FAIL wrap_non_zero got %0b expected 0", non_zero); end
    if (pending !== 8'd0) begin errors++; $display("FAIL wrap_early_pending got %0d expected 0", pending); end
    tick();
    checks++;
    if (pending !== 8'd1) begin errors++; $display("FAIL wrap_pending got %0d expected 1", pending); end
  endtask

  task automatic test_jump();
    clr = 1'b1; tick(); clr = 1'b0;
    set_src(4);
    repeat (3) tick();
    checks += 2;
    if (val !== 4'd4)     begin errors++; $display("FAIL jump_val got %0d expected 4", val); end
    if (pending !== 8'd0) begin errors++; $display("FAIL jump_early_pending got %0d expected 0", pending); end
    tick();
    checks++;
    if (pending !== 8'd4) begin errors++; $display("FAIL jump_pending got %0d expected 4", pending); end
  endtask

  task automatic test_ovf();
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_src(m_src + 15);
      tick();
    end
    repeat (5) tick();
    checks += 2;
    if (pending !== 8'd255) begin errors++; $display("FAIL full_pending got %0d expected 255", pending); end
    if (ovf !== 0)          begin errors++; $display("FAIL full_ovf got %0b expected 0", ovf); end
    set_src(m_src + 1);
    repeat (4) tick();
    checks += 2;
    if (pending !== 8'd255) begin errors++; $display("FAIL sat_pending got %0d expected 255", pending); end
    if (ovf !== 1)          begin errors++; $display("FAIL sat_ovf got %0b expected 1", ovf); end
    pop_ready = 1'b1; tick(); pop_ready = 1'b0;
    checks += 2;
    if (pending !== 8'd254) begin errors++; $display("FAIL sat_drain got %0d expected 254", pending); end
    if (ovf !== 1)          begin errors++; $display("FAIL sat_sticky got %0b expected 1", ovf); end
    clr = 1'b1; tick(); clr = 1'b0;
    checks += 3;
    if (pending !== 8'd0)     begin errors++; $display("FAIL clr_pending got %0d expected 0", pending); end
    if (ovf !== 0)            begin errors++; $display("FAIL clr_ovf got %0b expected 0", ovf); end
    if (val !== 4'(m_src))    begin errors++; $display("FAIL clr_val got %0d expected %0d", val, m_src); end
  endtask

  task automatic test_back_to_back();
    clr = 1'b1; tick(); clr = 1'b0;
    set_src(m_src + 3);
    repeat (5) tick();
    checks++;
    if (pending !== 8'd3) begin errors++; $display("FAIL b2b_pre got %0d expected 3", pending); end
    set_src(m_src + 1);
    repeat (3) tick();
    pop_ready = 1'b1; tick(); pop_ready = 1'b0;
    checks++;
    if (pending !== 8'd3) begin errors++; $display("FAIL b2b_pop_and_delta got %0d expected 3", pending); end
    set_src(m_src + 2);
    tick();
    reset = 1'b1; set_src(0);
    tick();
    checks += 5;
    if (val !== 4'd0)     begin errors++; $display("FAIL midrst_val got %0d expected 0", val); end
    if (non_zero !== 0)   begin errors++; $display("FAIL midrst_non_zero got %0b expected 0", non_zero); end
    if (pending !== 8'd0) begin errors++; $display("FAIL midrst_pending got %0d expected 0", pending); end
    if (pop_valid !== 0)  begin errors++; $display("FAIL midrst_pop_valid got %0b expected 0", pop_valid); end
    if (ovf !== 0)        begin errors++; $display("FAIL midrst_ovf got %0b expected 0", ovf); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      checks += 5;
      if (val !== 4'(m_val))
        begin errors++; $display("FAIL rand_val cyc %0d got %0d expected %0d", n, val, m_val); end
      if (non_zero !== (m_val != 0))
        begin errors++; $display("FAIL rand_non_zero cyc %0d got %0b expected %0b", n, non_zero, m_val != 0); end
      if (pending !== 8'(m_pending))
        begin errors++; $display("FAIL rand_pending cyc %0d got %0d expected %0d", n, pending, m_pending); end
      if (pop_valid !== (m_pending != 0))
        begin errors++; $display("FAIL rand_pop_valid cyc %0d got %0b expected %0b", n, pop_valid, m_pending != 0); end
      if (ovf !== m_ovf)
        begin errors++; $display("FAIL rand_ovf cyc %0d got %0b expected %0b", n, ovf, m_ovf); end
      reset     = ($urandom_range(0, 299) == 0);
      clr       = ($urandom_range(0, 59) == 0);
      pop_ready = ($urandom_range(0, 2) != 0);
      if (reset) set_src(0);
      else if ($urandom_range(0, 19) == 0) set_src(m_src + $urandom_range(4, 15));
      else set_src(m_src + $urandom_range(0, 3));
      tick();
    end
    reset = 1'b0; clr = 1'b0; pop_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steps();
    test_wrap();
    test_jump();
    test_ovf();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
